// File: rtl/minterm_sweep_if.sv
`default_nettype none
// ============================================================================
//  Module      : minterm_sweep_if
//  Description : Stimulus/result bundle between the minterm sweeper and its
//                controller (start, f_in in; stimulus and results out).
//  Revision    : 1.0  initial release
// ============================================================================
interface minterm_sweep_if;
    logic        start;
    logic        f_in;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] table_out;
    logic [4:0]  fail_count;
    logic [3:0]  first_fail;
    logic        first_fail_valid;

    modport master (
        output start, f_in,
        input  a, b, c, d, busy, done, pass,
        input  table_out, fail_count, first_fail, first_fail_valid
    );

    modport slave (
        input  start, f_in,
        output a, b, c, d, busy, done, pass,
        output table_out, fail_count, first_fail, first_fail_valid
    );
endinterface
`default_nettype wire

// File: rtl/minterm_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : minterm_sweep
//  Description : Steps {a,b,c,d} through 0..15, samples f_in after a settle
//                window and scores the measured truth table against EXPECTED.
//  Revision    : 1.0  initial release
// ============================================================================
module minterm_sweep #(
    parameter logic [15:0] EXPECTED = 16'h0727,
    parameter int unsigned SETTLE   = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    minterm_sweep_if.slave  bus
);

    localparam logic [3:0] c_settle   = 4'(SETTLE);
    localparam logic [3:0] c_last_idx = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  wait_q, wait_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [15:0] table_q, table_d;
    logic [4:0]  fail_count_q, fail_count_d;
    logic [3:0]  first_fail_q, first_fail_d;
    logic        first_fail_valid_q, first_fail_valid_d;
    logic        mismatch;

    always_comb begin
        state_d            = state_q;
        idx_d              = idx_q;
        wait_d             = wait_q;
        busy_d             = busy_q;
        done_d             = done_q;
        pass_d             = pass_q;
        table_d            = table_q;
        fail_count_d       = fail_count_q;
        first_fail_d       = first_fail_q;
        first_fail_valid_d = first_fail_valid_q;
        mismatch           = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d            = ST_APPLY;
                    idx_d              = 4'd0;
                    wait_d             = c_settle;
                    busy_d             = 1'b1;
                    done_d             = 1'b0;
                    pass_d             = 1'b0;
                    table_d            = 16'd0;
                    fail_count_d       = 5'd0;
                    first_fail_d       = 4'd0;
                    first_fail_valid_d = 1'b0;
                end
            end

            ST_APPLY: begin
                if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    // Last hold cycle of this minterm: capture and score f_in.
                    table_d[idx_q] = bus.f_in;
                    mismatch       = (bus.f_in != EXPECTED[idx_q]);
                    if (mismatch) begin
                        fail_count_d = fail_count_q + 5'd1;
                        if (!first_fail_valid_q) begin
                            first_fail_d       = idx_q;
                            first_fail_valid_d = 1'b1;
                        end
                    end

                    if (idx_q == c_last_idx) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (fail_count_d == 5'd0);
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        wait_d = c_settle;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= ST_IDLE;
            idx_q              <= 4'd0;
            wait_q             <= 4'd0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            pass_q             <= 1'b0;
            table_q            <= 16'd0;
            fail_count_q       <= 5'd0;
            first_fail_q       <= 4'd0;
            first_fail_valid_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            idx_q              <= idx_d;
            wait_q             <= wait_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            pass_q             <= pass_d;
            table_q            <= table_d;
            fail_count_q       <= fail_count_d;
            first_fail_q       <= first_fail_d;
            first_fail_valid_q <= first_fail_valid_d;
        end
    end

    // Stimulus comes straight from the idx register, so it is glitch-free.
    assign bus.a                = idx_q[3];
    assign bus.b                = idx_q[2];
    assign bus.c                = idx_q[1];
    assign bus.d                = idx_q[0];
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.table_out        = table_q;
    assign bus.fail_count       = fail_count_q;
    assign bus.first_fail       = first_fail_q;
    assign bus.first_fail_valid = first_fail_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_minterm_sweep.sv
`default_nettype none
// ============================================================================
//  Module      : tb_minterm_sweep
//  Description : Directed bench for minterm_sweep (SETTLE=1 and SETTLE=0).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_minterm_sweep;

    localparam logic [15:0] GOLD = 16'h0727;

    typedef struct {
        logic [15:0] tbl;
        logic [4:0]  fc;
        logic [3:0]  ff;
        logic        ffv;
        logic        pass;
        int          latency;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_drv = 1'b0;
    logic sel = 1'b1;       // 1: SETTLE=1 instance, 0: SETTLE=0 instance
    int   mode_r = 0;       // 0 correct, 1 tied low, 2 inverted at minterm 5

    int errors = 0;
    int checks = 0;

    res_t       exp_q[$];
    logic [3:0] stim_q[$];

    minterm_sweep_if if1 ();
    minterm_sweep_if if0 ();

    minterm_sweep #(.EXPECTED(GOLD), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    minterm_sweep #(.EXPECTED(GOLD), .SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

    always #5 clk = ~clk;

    function automatic logic model_f(input int mode, input logic [3:0] i);
        logic a, b, c, d, f;
        {a, b, c, d} = i;
        f = (~b & ~c) | (~b & ~d) | (~a & b & ~c & d);
        case (mode)
            1:       return 1'b0;
            2:       return (i == 4'd5) ? ~f : f;
            default: return f;
        endcase
    endfunction

    assign if1.f_in  = model_f(mode_r, {if1.a, if1.b, if1.c, if1.d});
    assign if0.f_in  = model_f(0, {if0.a, if0.b, if0.c, if0.d});
    assign if1.start = start_drv & sel;
    assign if0.start = start_drv & ~sel;

    logic [3:0]  cur_idx;
    logic        cur_busy, cur_done, cur_pass, cur_ffv;
    logic [15:0] cur_tbl;
    logic [4:0]  cur_fc;
    logic [3:0]  cur_ff;
    assign cur_idx  = sel ? {if1.a, if1.b, if1.c, if1.d} : {if0.a, if0.b, if0.c, if0.d};
    assign cur_busy = sel ? if1.busy : if0.busy;
    assign cur_done = sel ? if1.done : if0.done;
    assign cur_pass = sel ? if1.pass : if0.pass;
    assign cur_ffv  = sel ? if1.first_fail_valid : if0.first_fail_valid;
    assign cur_tbl  = sel ? if1.table_out : if0.table_out;
    assign cur_fc   = sel ? if1.fail_count : if0.fail_count;
    assign cur_ff   = sel ? if1.first_fail : if0.first_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_idx"},  {28'd0, cur_idx}, 32'd0);
        chk({tag, "_busy"}, {31'd0, cur_busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, cur_done}, 32'd0);
        chk({tag, "_pass"}, {31'd0, cur_pass}, 32'd0);
        chk({tag, "_tbl"},  {16'd0, cur_tbl}, 32'd0);
        chk({tag, "_fc"},   {27'd0, cur_fc}, 32'd0);
        chk({tag, "_ff"},   {28'd0, cur_ff}, 32'd0);
        chk({tag, "_ffv"},  {31'd0, cur_ffv}, 32'd0);
    endtask

    // Expected results come from the bench's own model, pushed at start time.
    task automatic push_expect(input int mode, input int settle);
        res_t e;
        e.tbl = 16'd0; e.fc = 5'd0; e.ff = 4'd0; e.ffv = 1'b0;
        for (int i = 0; i < 16; i++) begin
            e.tbl[i] = model_f(mode, 4'(i));
            if (e.tbl[i] != GOLD[i]) begin
                e.fc++;
                if (!e.ffv) begin
                    e.ff  = 4'(i);
                    e.ffv = 1'b1;
                end
            end
        end
        e.pass    = (e.fc == 5'd0);
        e.latency = 16 * (settle + 1);
        exp_q.push_back(e);
        for (int i = 0; i < 16; i++)
            for (int k = 0; k <= settle; k++)
                stim_q.push_back(4'(i));
    endtask

    task automatic run_sweep(input string tag, input int mode, input logic use1,
                             input int settle, input int inject_idx);
        res_t e;
        int   n;
        bit   seen, injected;
        sel    = use1;
        mode_r = mode;
        push_expect(mode, settle);
        @(negedge clk); start_drv = 1'b1;
        @(posedge clk); #1; start_drv = 1'b0;
        n = 0; seen = 0; injected = 0;
        while (n < 200 && !seen) begin
            if (cur_busy) begin
                if (stim_q.size() != 0) chk({tag, "_stim"}, {28'd0, cur_idx}, {28'd0, stim_q.pop_front()});
                else                    chk({tag, "_stim_overrun"}, {31'd0, cur_busy}, 32'd0);
            end
            if (inject_idx >= 0 && !injected && cur_idx == 4'(inject_idx)) begin
                start_drv = 1'b1;
                injected  = 1;
            end
            @(posedge clk); #1;
            start_drv = 1'b0;
            n++;
            if (cur_done) seen = 1;
        end
        e = exp_q.pop_front();
        chk({tag, "_latency"}, 32'(n), 32'(e.latency));
        chk({tag, "_stim_left"}, 32'(stim_q.size()), 32'd0);
        stim_q.delete();
        chk({tag, "_tbl"},  {16'd0, cur_tbl}, {16'd0, e.tbl});
        chk({tag, "_fc"},   {27'd0, cur_fc},  {27'd0, e.fc});
        chk({tag, "_ff"},   {28'd0, cur_ff},  {28'd0, e.ff});
        chk({tag, "_ffv"},  {31'd0, cur_ffv}, {31'd0, e.ffv});
        chk({tag, "_pass"}, {31'd0, cur_pass}, {31'd0, e.pass});
        chk({tag, "_busy"}, {31'd0, cur_busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_hold_done"}, {31'd0, cur_done}, 32'd1);
        chk({tag, "_hold_idx"},  {28'd0, cur_idx}, 32'd15);
        chk({tag, "_hold_tbl"},  {16'd0, cur_tbl}, {16'd0, e.tbl});
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        sel = 1'b1;
        chk_idle_reset("por1");
        sel = 1'b0;
        chk_idle_reset("por0");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        sel = 1'b1;
        chk({"idle_busy"}, {31'd0, cur_busy}, 32'd0);

        // 1: correct netlist
        run_sweep("t1", 0, 1'b1, 1, -1);
        chk("t1_tbl_lit", {16'd0, cur_tbl}, 32'h0727);
        // 2: f tied low, started from DONE
        run_sweep("t2", 1, 1'b1, 1, -1);
        chk("t2_fc_lit", {27'd0, cur_fc}, 32'd7);
        // 3: single fault at minterm 5
        run_sweep("t3", 2, 1'b1, 1, -1);
        chk("t3_tbl_lit", {16'd0, cur_tbl}, 32'h0707);
        chk("t3_ff_lit",  {28'd0, cur_ff},  32'd5);
        // 4: start pulse mid-sweep must be ignored
        run_sweep("t4", 0, 1'b1, 1, 6);

        // 5: reset mid-sweep at idx 7, then a clean sweep
        sel = 1'b1; mode_r = 1;
        @(negedge clk); start_drv = 1'b1;
        @(posedge clk); #1; start_drv = 1'b0;
        n = 0;
        while (cur_idx != 4'd7 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t5_reach_idx7", {28'd0, cur_idx}, 32'd7);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk_idle_reset("t5_rst");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("t5_stays_idle", {31'd0, cur_busy}, 32'd0);
        run_sweep("t5", 0, 1'b1, 1, -1);

        // 6: SETTLE=0 instance, one sample per cycle
        run_sweep("t6", 0, 1'b0, 0, -1);
        chk("t6_pass_lit", {31'd0, cur_pass}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
